// File: rtl/readout_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : readout_scheduler_if
// Purpose  : Bundles the record-push side (trigger/latch assembly) and the
//            SPI readout side of the readout scheduler into one port group.
// Ports    : sample_interrupt, event_in   - record push from the front end
//            sample_done                  - "frame shifted out" pulse from spi
//            spi_data, interrupt          - presented record and MCU IRQ (low)
//            veto_out, count, drop_count, overflow - status to front end
// Modports : slave  - the scheduler itself
//            master - whatever drives pushes and consumes the readout
// Revision : 1.0 - initial release
// ============================================================================
interface readout_scheduler_if #(
  parameter int DATA_W = 128,
  parameter int DEPTH  = 8
);
  logic                       sample_interrupt;
  logic [DATA_W-1:0]          event_in;
  logic                       sample_done;
  logic [DATA_W-1:0]          spi_data;
  logic                       interrupt;
  logic                       veto_out;
  logic [$clog2(DEPTH):0]     count;
  logic [7:0]                 drop_count;
  logic                       overflow;

  modport slave (
    input  sample_interrupt, event_in, sample_done,
    output spi_data, interrupt, veto_out, count, drop_count, overflow
  );

  modport master (
    output sample_interrupt, event_in, sample_done,
    input  spi_data, interrupt, veto_out, count, drop_count, overflow
  );
endinterface
`default_nettype wire

// File: rtl/readout_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : readout_scheduler
// Purpose  : Buffers assembled trigger records in a FIFO and presents them one
//            at a time to the SPI readout, raising the MCU interrupt (active
//            low) while a record is held on spi_data. Generates the front-end
//            veto from FIFO occupancy plus a post-push holdoff window.
// Ports    : sampling_clk - single clock
//            reset        - asynchronous, active-low
//            bus          - readout_scheduler_if.slave (push, readout, status)
// Revision : 1.0 - initial release
// ============================================================================
module readout_scheduler #(
  parameter int DATA_W      = 128,
  parameter int DEPTH       = 8,
  parameter int VETO_MARGIN = 1,
  parameter int HOLDOFF     = 16
) (
  input  wire                  sampling_clk,
  input  wire                  reset,
  readout_scheduler_if.slave   bus
);

  localparam int c_PTR_W  = $clog2(DEPTH);
  localparam int c_CNT_W  = c_PTR_W + 1;
  localparam int c_HOLD_W = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

  localparam logic [c_CNT_W-1:0]  c_FULL      = c_CNT_W'(DEPTH);
  localparam logic [c_CNT_W-1:0]  c_VETO_LVL  = c_CNT_W'(DEPTH - VETO_MARGIN);
  localparam logic [c_HOLD_W-1:0] c_HOLD_LOAD = c_HOLD_W'(HOLDOFF);

  typedef enum logic [1:0] {
    S_EMPTY   = 2'd0,
    S_LOAD    = 2'd1,
    S_PRESENT = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_next;

  logic [DATA_W-1:0]    r_mem [DEPTH];
  logic [c_PTR_W-1:0]   r_wr_ptr;
  logic [c_PTR_W-1:0]   r_rd_ptr;
  logic [c_CNT_W-1:0]   r_count;
  logic [c_CNT_W-1:0]   w_count_next;
  logic [7:0]           r_drop_count;
  logic                 r_overflow;
  logic [c_HOLD_W-1:0]  r_hold;
  logic [c_HOLD_W-1:0]  w_hold_next;
  logic                 r_veto;
  logic                 r_interrupt;
  logic [DATA_W-1:0]    r_spi_data;

  logic                 w_full;
  logic                 w_push;
  logic                 w_drop;
  logic                 w_pop;

  // Fullness is judged on the pre-pop count, so a push that coincides with a
  // pop while full is still dropped.
  assign w_full = (r_count == c_FULL);
  assign w_push = bus.sample_interrupt && !w_full;
  assign w_drop = bus.sample_interrupt &&  w_full;
  // sample_done only means something while a record is being presented.
  assign w_pop  = bus.sample_done && (r_state == S_PRESENT);

  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + c_CNT_W'(1);
      2'b01:   w_count_next = r_count - c_CNT_W'(1);
      default: w_count_next = r_count;
    endcase
  end

  always_comb begin
    w_hold_next = r_hold;
    if (w_push) begin
      w_hold_next = c_HOLD_LOAD;
    end else if (r_hold != '0) begin
      w_hold_next = r_hold - c_HOLD_W'(1);
    end
  end

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge sampling_clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_EMPTY: begin
        if (r_count != '0) w_state_next = S_LOAD;
      end
      S_LOAD: begin
        w_state_next = S_PRESENT;
      end
      S_PRESENT: begin
        if (w_pop) w_state_next = (w_count_next != '0) ? S_LOAD : S_EMPTY;
      end
      default: begin
        w_state_next = S_EMPTY;
      end
    endcase
  end

  // ---------------------------------------------------------------- storage
  // Record storage carries no reset; only slots covered by count are ever read.
  always_ff @(posedge sampling_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= bus.event_in;
    end
  end

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge sampling_clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_drop_count <= '0;
      r_overflow   <= 1'b0;
      r_hold       <= '0;
      r_veto       <= 1'b0;
      r_interrupt  <= 1'b1;
      r_spi_data   <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      r_count <= w_count_next;

      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_count != 8'hFF) r_drop_count <= r_drop_count + 8'd1;
      end

      r_hold <= w_hold_next;
      r_veto <= (w_count_next >= c_VETO_LVL) || (w_hold_next != '0);

      // Registered so the MCU interrupt line never glitches on state decode.
      r_interrupt <= (w_state_next != S_PRESENT);

      // rd_ptr was already advanced by the pop that led into LOAD.
      if (r_state == S_LOAD) r_spi_data <= r_mem[r_rd_ptr];
    end
  end

  assign bus.spi_data   = r_spi_data;
  assign bus.interrupt  = r_interrupt;
  assign bus.veto_out   = r_veto;
  assign bus.count      = r_count;
  assign bus.drop_count = r_drop_count;
  assign bus.overflow   = r_overflow;

endmodule
`default_nettype wire
